// File: rtl/lifm_lowering_unit.sv
// lifm_lowering_unit
// Buffers one IFM tile and lowers it (im2col) into LIFM columns of
// STEP_RANGE words, one column per kernel element per output window.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; oversized or empty tiles raise cfg_err here
// LOAD  | accepting IFM words into the tile buffer (ifm_ready high)
// GEN   | packing one column word per cycle, j = 0..STEP_RANGE-1
// OUT   | column presented; held until out_ready
// DONE  | one-cycle done pulse, then back to IDLE
module lifm_lowering_unit #(
  parameter int WORD_WIDTH = 8,
  parameter int STEP_RANGE = 128,
  parameter int IFM_DEPTH  = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [WORD_WIDTH-1:0]            if_width,
  input  logic [WORD_WIDTH-1:0]            if_height,
  input  logic [WORD_WIDTH-1:0]            ke_width,
  input  logic [WORD_WIDTH-1:0]            ke_height,
  input  logic [WORD_WIDTH-1:0]            of_width,
  input  logic [WORD_WIDTH-1:0]            of_height,
  input  logic [WORD_WIDTH-1:0]            stride,
  input  logic                             ifm_valid,
  input  logic [WORD_WIDTH-1:0]            ifm_data,
  output logic                             ifm_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_WIDTH-1:0]            kidx,
  output logic [WORD_WIDTH*STEP_RANGE-1:0] lifm_column,
  output logic                             busy,
  output logic                             done,
  output logic                             cfg_err
);

  localparam int AW = ADDR_WIDTH + WORD_WIDTH;
  localparam int JW = $clog2(STEP_RANGE);
  localparam int PW = 2 * WORD_WIDTH + JW + 1;
  localparam int CW = ADDR_WIDTH + 1;
  localparam int SW = 2 * WORD_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GEN, S_OUT, S_DONE} state_t;

  state_t state_q, state_d;

  logic [WORD_WIDTH-1:0] cfg_iw, cfg_fw, cfg_fh, cfg_ow, cfg_oh, cfg_s;
  logic [CW-1:0]         npix_q, wcnt_q;
  logic [JW-1:0]         j_q;
  logic [WORD_WIDTH-1:0] ox_q, oy_q, base_ox_q, base_oy_q;
  logic [WORD_WIDTH-1:0] kh_q, kw_q, kidx_q;
  logic [PW-1:0]         base_pos_q;
  logic [WORD_WIDTH*STEP_RANGE-1:0] col_q;

  logic [WORD_WIDTH-1:0] ifm_buf [IFM_DEPTH];

  logic [SW-1:0]         ifm_size;
  logic                  cfg_ok;
  logic [PW-1:0]         tot_pos, pos, next_base;
  logic                  last_word, last_k, more_windows, load_last, ox_wrap;
  logic [AW-1:0]         row, addr_full;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [WORD_WIDTH-1:0] word;
  logic                  unused_addr_hi;

  // geometry checks, current position and buffer address for the word being packed
  always_comb begin
    ifm_size     = SW'(if_height) * SW'(if_width);
    cfg_ok       = (ifm_size != '0) && (ifm_size <= SW'(IFM_DEPTH));
    tot_pos      = PW'(cfg_oh) * PW'(cfg_ow);
    pos          = base_pos_q + PW'(j_q);
    next_base    = base_pos_q + PW'(STEP_RANGE);
    last_word    = (j_q == JW'(STEP_RANGE - 1));
    last_k       = (kw_q == cfg_fw - 8'd1) && (kh_q == cfg_fh - 8'd1);
    more_windows = (next_base < tot_pos);
    load_last    = (wcnt_q == npix_q - 1'b1);
    ox_wrap      = (ox_q == cfg_ow - 8'd1);
    row          = AW'(oy_q) * AW'(cfg_s) + AW'(kh_q);
    addr_full    = row * AW'(cfg_iw) + AW'(ox_q) * AW'(cfg_s) + AW'(kw_q);
    rd_addr      = addr_full[ADDR_WIDTH-1:0];
    word         = (pos < tot_pos) ? ifm_buf[rd_addr] : '0;
  end

  // high address bits are dropped on purpose: the buffer index wraps at IFM_DEPTH
  assign unused_addr_hi = ^addr_full[AW-1:ADDR_WIDTH];

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && cfg_ok) state_d = S_LOAD;
      S_LOAD: if (ifm_valid && load_last) state_d = S_GEN;
      S_GEN:  if (last_word) state_d = S_OUT;
      S_OUT:  if (out_ready) begin
                if (!last_k || more_windows) state_d = S_GEN;
                else                         state_d = S_DONE;
              end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ifm_ready   = (state_q == S_LOAD);
  assign out_valid   = (state_q == S_OUT);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign kidx        = kidx_q;
  assign lifm_column = col_q;

  // config latch and sticky configuration error, updated only by start in IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_iw  <= '0;
      cfg_fw  <= '0;
      cfg_fh  <= '0;
      cfg_ow  <= '0;
      cfg_oh  <= '0;
      cfg_s   <= '0;
      npix_q  <= '0;
      cfg_err <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      if (cfg_ok) begin
        cfg_iw  <= if_width;
        cfg_fw  <= ke_width;
        cfg_fh  <= ke_height;
        cfg_ow  <= of_width;
        cfg_oh  <= of_height;
        cfg_s   <= stride;
        npix_q  <= ifm_size[CW-1:0];
        cfg_err <= 1'b0;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  // tile buffer write port; contents are not reset
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && ifm_valid) ifm_buf[wcnt_q[ADDR_WIDTH-1:0]] <= ifm_data;
  end

  // load counter, position/kernel counters and column packing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_q     <= '0;
      j_q        <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      base_ox_q  <= '0;
      base_oy_q  <= '0;
      base_pos_q <= '0;
      kh_q       <= '0;
      kw_q       <= '0;
      kidx_q     <= '0;
      col_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: wcnt_q <= '0;
        S_LOAD: if (ifm_valid) begin
          wcnt_q <= wcnt_q + 1'b1;
          if (load_last) begin
            j_q        <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            base_ox_q  <= '0;
            base_oy_q  <= '0;
            base_pos_q <= '0;
            kh_q       <= '0;
            kw_q       <= '0;
            kidx_q     <= '0;
          end
        end
        S_GEN: begin
          col_q[j_q*WORD_WIDTH +: WORD_WIDTH] <= word;
          j_q <= last_word ? '0 : j_q + 1'b1;
          if (ox_wrap) begin
            ox_q <= '0;
            oy_q <= oy_q + 1'b1;
          end else begin
            ox_q <= ox_q + 1'b1;
          end
        end
        S_OUT: if (out_ready) begin
          if (!last_k) begin
            // same window again with the next kernel element
            kidx_q <= kidx_q + 1'b1;
            ox_q   <= base_ox_q;
            oy_q   <= base_oy_q;
            if (kw_q == cfg_fw - 8'd1) begin
              kw_q <= '0;
              kh_q <= kh_q + 1'b1;
            end else begin
              kw_q <= kw_q + 1'b1;
            end
          end else begin
            // ox/oy already sit on the first position of the next window
            kidx_q     <= '0;
            kh_q       <= '0;
            kw_q       <= '0;
            base_pos_q <= next_base;
            base_ox_q  <= ox_q;
            base_oy_q  <= oy_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lifm_lowering_unit.sv
// Testbench for lifm_lowering_unit with an 8-word column.
module tb_lifm_lowering_unit;
  localparam int WW    = 8;
  localparam int SR    = 8;
  localparam int DEPTH = 1024;
  localparam int CWID  = WW * SR;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [WW-1:0] if_width = '0, if_height = '0, ke_width = '0, ke_height = '0;
  logic [WW-1:0] of_width = '0, of_height = '0, stride = '0;
  logic ifm_valid = 1'b0;
  logic [WW-1:0] ifm_data = '0;
  logic out_ready = 1'b0;
  logic ifm_ready, out_valid, busy, done, cfg_err;
  logic [WW-1:0] kidx;
  logic [CWID-1:0] lifm_column;

  lifm_lowering_unit #(.WORD_WIDTH(WW), .STEP_RANGE(SR), .IFM_DEPTH(DEPTH), .ADDR_WIDTH(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .if_width(if_width), .if_height(if_height), .ke_width(ke_width), .ke_height(ke_height),
    .of_width(of_width), .of_height(of_height), .stride(stride),
    .ifm_valid(ifm_valid), .ifm_data(ifm_data), .ifm_ready(ifm_ready),
    .out_valid(out_valid), .out_ready(out_ready), .kidx(kidx), .lifm_column(lifm_column),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [WW-1:0]   ifm_mem [DEPTH];
  logic [CWID-1:0] exp_col[$], got_col[$];
  logic [WW-1:0]   exp_kidx[$], got_kidx[$];
  int              hs_cyc[$];
  int              done_cnt, unstable_cnt, timed_out;
  logic            busy_after;

  function automatic logic [CWID-1:0] make_col4(input int a, input int b, input int c, input int d);
    logic [CWID-1:0] v;
    v = '0;
    v[0*WW +: WW] = WW'(a);
    v[1*WW +: WW] = WW'(b);
    v[2*WW +: WW] = WW'(c);
    v[3*WW +: WW] = WW'(d);
    return v;
  endfunction

  // im2col straight from the definition: windows of SR positions, every kernel element per window
  task automatic build_expected(input int iw, input int fw, input int fh, input int s,
                                input int ow, input int oh);
    int tot, p, a;
    logic [CWID-1:0] col;
    exp_col.delete();
    exp_kidx.delete();
    tot = ow * oh;
    for (int base = 0; base < tot; base += SR) begin
      for (int k = 0; k < fh * fw; k++) begin
        col = '0;
        for (int j = 0; j < SR; j++) begin
          p = base + j;
          if (p < tot) begin
            a = (((p / ow) * s + k / fw) * iw + (p % ow) * s + k % fw) % DEPTH;
            col[j*WW +: WW] = ifm_mem[a];
          end
        end
        exp_col.push_back(col);
        exp_kidx.push_back(WW'(k));
      end
    end
  endtask

  task automatic start_job(input int iw, input int ih, input int fw, input int fh,
                           input int s, input int ow, input int oh);
    @(negedge clk);
    if_width = WW'(iw); if_height = WW'(ih); ke_width = WW'(fw); ke_height = WW'(fh);
    stride = WW'(s); of_width = WW'(ow); of_height = WW'(oh);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_ifm(input int n);
    int i, budget;
    logic acc;
    i = 0;
    budget = 0;
    while (i < n && budget < 5000) begin
      ifm_valid = ($urandom_range(0, 3) != 0);
      ifm_data  = ifm_mem[i];
      acc = ifm_valid && ifm_ready;
      @(posedge clk);
      if (acc) i++;
      budget++;
      @(negedge clk);
    end
    ifm_valid = 1'b0;
    checks++;
    if (i != n) begin
      failures++;
      $display("FAIL load_words: accepted %0d, required %0d", i, n);
    end
  endtask

  // mode 0: ready high; mode 1: 5 stall cycles per column; mode 2: random ready
  task automatic collect(input int mode, input int max_cols);
    int budget, hold, post;
    bit new_col, fin, hs;
    logic [CWID-1:0] held, cap_col;
    logic [WW-1:0] heldk, cap_k;
    got_col.delete(); got_kidx.delete(); hs_cyc.delete();
    done_cnt = 0; unstable_cnt = 0;
    budget = 0; hold = 0; post = 0; new_col = 1'b1; fin = 1'b0;
    held = '0; heldk = '0;
    while (!fin && budget < 20000) begin
      if (out_valid) begin
        if (new_col) begin
          held = lifm_column; heldk = kidx; new_col = 1'b0; hold = 0;
        end else if (lifm_column !== held || kidx !== heldk) begin
          unstable_cnt++;
        end
        case (mode)
          0: out_ready = 1'b1;
          1: begin out_ready = (hold >= 5); if (hold < 5) hold++; end
          default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
      end else begin
        out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (done) done_cnt++;
      if (done_cnt > 0) post++;
      hs = out_valid && out_ready;
      cap_col = lifm_column;
      cap_k = kidx;
      @(posedge clk);
      if (hs) begin
        got_col.push_back(cap_col);
        got_kidx.push_back(cap_k);
        hs_cyc.push_back(budget);
        new_col = 1'b1;
      end
      if (max_cols > 0 && got_col.size() == max_cols) fin = 1'b1;
      if (post >= 3) fin = 1'b1;
      budget++;
      @(negedge clk);
    end
    timed_out = fin ? 0 : 1;
    busy_after = busy;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({ifm_ready, out_valid, busy, done, cfg_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 00000", {ifm_ready, out_valid, busy, done, cfg_err});
    end
    checks++;
    if (kidx !== '0 || lifm_column !== '0) begin
      failures++;
      $display("FAIL reset_data: kidx %h col %h required 0", kidx, lifm_column);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifm_ready, out_valid, busy, done} !== 4'b0) begin
      failures++;
      $display("FAIL reset_release: got %b required 0000", {ifm_ready, out_valid, busy, done});
    end
  endtask

  task automatic run_tile1(input int mode);
    for (int i = 0; i < 16; i++) ifm_mem[i] = WW'(i);
    build_expected(4, 3, 3, 1, 2, 2);
    start_job(4, 4, 3, 3, 1, 2, 2);
    load_ifm(16);
    collect(mode, 0);
  endtask

  task automatic test_basic();
    int n, bad_iv;
    run_tile1(0);
    checks++;
    if (timed_out != 0 || got_col.size() != 9) begin
      failures++;
      $display("FAIL basic_count: got %0d columns timeout=%0d, required 9", got_col.size(), timed_out);
    end
    n = (got_col.size() < exp_col.size()) ? got_col.size() : exp_col.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_col[i] !== exp_col[i] || got_kidx[i] !== exp_kidx[i]) begin
        failures++;
        $display("FAIL basic_col%0d: got k=%0d %h required k=%0d %h", i, got_kidx[i], got_col[i], exp_kidx[i], exp_col[i]);
      end
    end
    if (got_col.size() == 9) begin
      checks++;
      if (got_col[0] !== make_col4(0, 1, 4, 5)) begin
        failures++; $display("FAIL basic_kidx0: got %h required %h", got_col[0], make_col4(0, 1, 4, 5));
      end
      checks++;
      if (got_col[4] !== make_col4(5, 6, 9, 10)) begin
        failures++; $display("FAIL basic_kidx4: got %h required %h", got_col[4], make_col4(5, 6, 9, 10));
      end
      checks++;
      if (got_col[8] !== make_col4(10, 11, 14, 15)) begin
        failures++; $display("FAIL basic_kidx8: got %h required %h", got_col[8], make_col4(10, 11, 14, 15));
      end
    end
    checks++;
    if (done_cnt != 1 || busy_after !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: done pulses %0d busy %b, required 1 and 0", done_cnt, busy_after);
    end
    bad_iv = 0;
    for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] - hs_cyc[i-1] != SR + 1) bad_iv++;
    checks++;
    if (bad_iv != 0 || hs_cyc.size() < 2) begin
      failures++;
      $display("FAIL basic_throughput: %0d intervals differ from %0d cycles", bad_iv, SR + 1);
    end
  endtask

  task automatic test_stride();
    int n;
    for (int i = 0; i < 25; i++) ifm_mem[i] = WW'(i);
    build_expected(5, 3, 3, 2, 2, 2);
    start_job(5, 5, 3, 3, 2, 2, 2);
    load_ifm(25);
    collect(0, 0);
    checks++;
    if (timed_out != 0 || got_col.size() != 9) begin
      failures++;
      $display("FAIL stride_count: got %0d required 9", got_col.size());
    end
    n = (got_col.size() < exp_col.size()) ? got_col.size() : exp_col.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_col[i] !== exp_col[i] || got_kidx[i] !== exp_kidx[i]) begin
        failures++;
        $display("FAIL stride_col%0d: got %h required %h", i, got_col[i], exp_col[i]);
      end
    end
    if (got_col.size() == 9) begin
      checks++;
      if (got_col[0] !== make_col4(0, 2, 10, 12) || got_col[8] !== make_col4(12, 14, 22, 24)) begin
        failures++;
        $display("FAIL stride_spot: got %h / %h required %h / %h", got_col[0], got_col[8],
                 make_col4(0, 2, 10, 12), make_col4(12, 14, 22, 24));
      end
    end
  endtask

  task automatic test_one_by_one();
    int n;
    for (int i = 0; i < 36; i++) ifm_mem[i] = WW'(i);
    build_expected(6, 1, 1, 1, 6, 6);
    start_job(6, 6, 1, 1, 1, 6, 6);
    load_ifm(36);
    collect(0, 0);
    checks++;
    if (timed_out != 0 || got_col.size() != 5) begin
      failures++;
      $display("FAIL k1_count: got %0d required 5", got_col.size());
    end
    n = (got_col.size() < exp_col.size()) ? got_col.size() : exp_col.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_col[i] !== exp_col[i] || got_kidx[i] !== 8'd0) begin
        failures++;
        $display("FAIL k1_col%0d: got k=%0d %h required k=0 %h", i, got_kidx[i], got_col[i], exp_col[i]);
      end
    end
    if (got_col.size() == 5) begin
      checks++;
      if (got_col[4] !== make_col4(32, 33, 34, 35)) begin
        failures++;
        $display("FAIL k1_last: got %h required %h", got_col[4], make_col4(32, 33, 34, 35));
      end
    end
  endtask

  task automatic test_stall();
    int n;
    run_tile1(1);
    checks++;
    if (timed_out != 0 || got_col.size() != 9 || done_cnt != 1) begin
      failures++;
      $display("FAIL stall_count: got %0d cols %0d done, required 9 and 1", got_col.size(), done_cnt);
    end
    checks++;
    if (unstable_cnt != 0) begin
      failures++;
      $display("FAIL stall_hold: %0d changes while stalled, required 0", unstable_cnt);
    end
    n = (got_col.size() < exp_col.size()) ? got_col.size() : exp_col.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_col[i] !== exp_col[i] || got_kidx[i] !== exp_kidx[i]) begin
        failures++;
        $display("FAIL stall_col%0d: got %h required %h", i, got_col[i], exp_col[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < 16; i++) ifm_mem[i] = WW'(i);
    start_job(4, 4, 3, 3, 1, 2, 2);
    load_ifm(16);
    collect(0, 3);
    checks++;
    if (kidx !== 8'd3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre: kidx %0d busy %b, required 3 and 1", kidx, busy);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ifm_ready, out_valid, busy, done, cfg_err} !== 5'b0 || kidx !== '0 || lifm_column !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: flags %b kidx %0d col %h, required all 0",
               {ifm_ready, out_valid, busy, done, cfg_err}, kidx, lifm_column);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_tile1(0);
    checks++;
    if (timed_out != 0 || got_col.size() != 9) begin
      failures++;
      $display("FAIL midreset_count: got %0d required 9", got_col.size());
    end
    n = (got_col.size() < exp_col.size()) ? got_col.size() : exp_col.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_col[i] !== exp_col[i] || got_kidx[i] !== exp_kidx[i]) begin
        failures++;
        $display("FAIL midreset_col%0d: got %h required %h", i, got_col[i], exp_col[i]);
      end
    end
  endtask

  task automatic test_cfg_err();
    start_job(40, 40, 3, 3, 1, 38, 38);
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || ifm_ready !== 1'b0) begin
      failures++;
      $display("FAIL cfgerr_big: err %b busy %b ready %b, required 1 0 0", cfg_err, busy, ifm_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cfgerr_sticky: err %b busy %b, required 1 0", cfg_err, busy);
    end
    for (int i = 0; i < 4; i++) ifm_mem[i] = WW'($urandom);
    build_expected(2, 1, 1, 1, 2, 2);
    start_job(2, 2, 1, 1, 1, 2, 2);
    checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL cfgerr_clear: err %b busy %b, required 0 1", cfg_err, busy);
    end
    load_ifm(4);
    collect(0, 0);
    checks++;
    if (got_col.size() != 1 || got_col[0] !== exp_col[0]) begin
      failures++;
      $display("FAIL cfgerr_job: got %0d columns, required 1 matching column", got_col.size());
    end
    start_job(0, 5, 1, 1, 1, 1, 1);
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cfgerr_zero: err %b busy %b, required 1 0", cfg_err, busy);
    end
  endtask

  task automatic test_random();
    int iw, ih, fw, fh, s, ow, oh, n;
    for (int it = 0; it < 4; it++) begin
      ow = $urandom_range(1, 5); oh = $urandom_range(1, 5);
      fw = $urandom_range(1, 3); fh = $urandom_range(1, 3);
      s  = $urandom_range(1, 2);
      iw = (ow - 1) * s + fw; ih = (oh - 1) * s + fh;
      for (int i = 0; i < iw * ih; i++) ifm_mem[i] = WW'($urandom);
      build_expected(iw, fw, fh, s, ow, oh);
      start_job(iw, ih, fw, fh, s, ow, oh);
      load_ifm(iw * ih);
      start = 1'b1; if_width = 8'd1; stride = 8'd3;
      ifm_valid = 1'b1; ifm_data = 8'hA5;
      @(negedge clk);
      start = 1'b0;
      collect(2, 0);
      ifm_valid = 1'b0;
      checks++;
      if (timed_out != 0 || got_col.size() != exp_col.size() || done_cnt != 1) begin
        failures++;
        $display("FAIL rand%0d_count: got %0d cols %0d done, required %0d and 1", it,
                 got_col.size(), done_cnt, exp_col.size());
      end
      n = (got_col.size() < exp_col.size()) ? got_col.size() : exp_col.size();
      for (int i = 0; i < n; i++) begin
        checks++;
        if (got_col[i] !== exp_col[i] || got_kidx[i] !== exp_kidx[i]) begin
          failures++;
          $display("FAIL rand%0d_col%0d: got k=%0d %h required k=%0d %h", it, i,
                   got_kidx[i], got_col[i], exp_kidx[i], exp_col[i]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_stride();
    test_one_by_one();
    test_stall();
    test_reset_mid();
    test_cfg_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
